// File: rtl/ztex_host_port_pkg.sv
// Host-port definitions shared with the miner top: FSM state encodings,
// byte-bus protocol constants and the strobe bundle driven onto the bus.
package ztex_host_port_pkg;

    localparam int ZTEX_RD_BYTES = 44;
    localparam int ZTEX_WR_BYTES = 12;
    localparam int IDX_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_WS_LO = 3'd3,
        ST_WS_HI = 3'd4,
        ST_WR_LO = 3'd5,
        ST_WR_HI = 3'd6,
        ST_DONE  = 3'd7
    } host_state_t;

    typedef struct packed {
        logic rd_clk;
        logic wr_start;
        logic wr_clk;
    } strobe_t;

endpackage

// File: rtl/ztex_strobe_timer.sv
// Phase counter for the byte-bus strobes: phase_end marks the last of DIV
// cycles in the current strobe phase.
module ztex_strobe_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic phase_end
);

    logic [7:0] cnt;

    assign phase_end = (cnt == 8'(DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (restart || phase_end)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/ztex_host_port.sv
// Host-side initiator for the ZTEX miner byte bus: shifts a work word into
// the miner and reads its result buffer back on request.
module ztex_host_port
    import ztex_host_port_pkg::*;
#(
    parameter int RD_BYTES = ZTEX_RD_BYTES,
    parameter int WR_BYTES = ZTEX_WR_BYTES,
    parameter int DIV      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    work_valid,
    output logic                    work_ready,
    input  logic [8*RD_BYTES-1:0]   work_data,
    input  logic                    poll_req,
    output logic                    result_valid,
    output logic [8*WR_BYTES-1:0]   result_data,
    output logic                    busy,
    output logic [7:0]              read,
    output logic                    rd_clk,
    output logic                    wr_start,
    output logic                    wr_clk,
    input  logic [7:0]              write
);

    host_state_t             state, state_n;
    strobe_t                 strb_d;
    logic                    ready_d, rv_d;
    logic                    phase_end, restart;
    logic                    poll_pend;
    logic [IDX_W-1:0]        idx;
    logic [8*RD_BYTES-1:0]   sr;
    logic [8*WR_BYTES-1:0]   asm_q;
    logic                    last_rd, last_wr;

    assign last_rd = (idx == IDX_W'(RD_BYTES - 1));
    assign last_wr = (idx == IDX_W'(WR_BYTES - 1));

    // Holding the timer clear while idle aligns every first phase to a full DIV.
    assign restart = (state == ST_IDLE) || (state == ST_DONE);

    ztex_strobe_timer #(.DIV(DIV)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (work_valid)     state_n = ST_RD_LO;
                else if (poll_pend) state_n = ST_WS_LO;
            end
            ST_RD_LO: if (phase_end) state_n = ST_RD_HI;
            ST_RD_HI: if (phase_end) state_n = last_rd ? ST_IDLE : ST_RD_LO;
            ST_WS_LO: if (phase_end) state_n = ST_WS_HI;
            ST_WS_HI: if (phase_end) state_n = ST_WR_LO;
            ST_WR_LO: if (phase_end) state_n = last_wr ? ST_DONE : ST_WR_HI;
            ST_WR_HI: if (phase_end) state_n = ST_WR_LO;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobes line up with it.
    always_comb begin
        strb_d          = '0;
        strb_d.rd_clk   = (state_n == ST_RD_HI);
        strb_d.wr_start = (state_n == ST_WS_LO) || (state_n == ST_WS_HI);
        strb_d.wr_clk   = (state_n == ST_WS_HI) || (state_n == ST_WR_HI);
        ready_d         = (state_n == ST_IDLE);
        rv_d            = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_clk       <= 1'b0;
            wr_start     <= 1'b0;
            wr_clk       <= 1'b0;
            work_ready   <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            rd_clk       <= strb_d.rd_clk;
            wr_start     <= strb_d.wr_start;
            wr_clk       <= strb_d.wr_clk;
            work_ready   <= ready_d;
            busy         <= !ready_d;
            result_valid <= rv_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_pend   <= 1'b0;
            idx         <= '0;
            sr          <= '0;
            asm_q       <= '0;
            read        <= '0;
            result_data <= '0;
        end else begin
            if (state == ST_IDLE && state_n == ST_WS_LO)
                poll_pend <= 1'b0;
            else if (poll_req)
                poll_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (work_valid) begin
                        sr   <= work_data;
                        read <= work_data[7:0];
                        idx  <= '0;
                    end else if (poll_pend) begin
                        idx  <= '0;
                    end
                end
                ST_RD_HI: begin
                    if (phase_end) begin
                        sr  <= sr >> 8;
                        idx <= idx + IDX_W'(1);
                        if (!last_rd)
                            read <= sr[15:8];
                    end
                end
                ST_WR_LO: begin
                    // Bytes arrive low-first, so shifting in at the top leaves byte 0 in [7:0].
                    if (phase_end) begin
                        asm_q <= {write, asm_q[8*WR_BYTES-1:8]};
                        idx   <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: result_data <= asm_q;
                default: ;
            endcase
        end
    end

endmodule
